// File: rtl/bus_rr_scheduler.sv
// Round-robin bus scheduler/router: grants one pending device FIFO, pops its head
// packet and pushes it to the decoded destination(s). Optional macro: BUS_RR_LOOPBACK_EN.
module bus_rr_scheduler #(
   parameter int         drvrs     = 4,
   parameter int         pckg_sz   = 16,
   parameter logic [7:0] broadcast = 8'hFF
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [drvrs-1:0]           pndng,
   input  logic [drvrs*pckg_sz-1:0]   D_pop,
   output logic [drvrs-1:0]           pop,
   output logic [drvrs-1:0]           push,
   output logic [pckg_sz-1:0]         D_push,
   output logic                       busy,
   output logic [7:0]                 gnt_id,
   output logic [15:0]                drop_cnt
);

   localparam logic [drvrs-1:0] ONE  = {{(drvrs-1){1'b0}}, 1'b1};
   localparam logic [8:0]       NDEV = 9'(drvrs);

   typedef enum logic [1:0] {S_IDLE, S_POP, S_ROUTE} state_t;

   state_t               r_state;
   state_t               w_next;
   logic [7:0]           r_gnt;
   logic [7:0]           r_rr_ptr;
   logic [pckg_sz-1:0]   r_data;
   logic [15:0]          r_drop_cnt;

   logic [7:0]           w_winner;
   logic [7:0]           w_dst;
   logic [pckg_sz-1:0]   w_slice;
   logic [drvrs-1:0]     w_src;
   logic [drvrs-1:0]     w_pop;
   logic [drvrs-1:0]     w_push;
   logic                 w_busy;
   logic                 w_drop;
   int                   w_best;

   // Winner is the pending device at the smallest circular distance past rr_ptr
   always_comb begin
      w_winner = '0;
      w_best   = drvrs;
      for (int i = 0; i < drvrs; i++) begin
         if (pndng[i] && (((i + drvrs - 1 - int'(r_rr_ptr)) % drvrs) < w_best)) begin
            w_best   = (i + drvrs - 1 - int'(r_rr_ptr)) % drvrs;
            w_winner = 8'(i);
         end
      end
   end

   always_comb begin
      w_slice = '0;
      for (int i = 0; i < drvrs; i++) begin
         if (8'(i) == r_gnt) w_slice = D_pop[i*pckg_sz +: pckg_sz];
      end
   end

   assign w_src = ONE << r_gnt;
   assign w_dst = r_data[pckg_sz-1 -: 8];

   always_ff @(posedge clk) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      w_pop  = '0;
      w_busy = 1'b0;
      case (r_state)
         S_IDLE:  if (|pndng) w_next = S_POP;
         S_POP: begin
            w_pop  = w_src;
            w_busy = 1'b1;
            w_next = S_ROUTE;
         end
         S_ROUTE: begin
            w_busy = 1'b1;
            w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   // Destination decode; broadcast is checked first and never includes the source
   always_comb begin
      w_push = '0;
      w_drop = 1'b0;
      if (r_state == S_ROUTE) begin
         if (w_dst == broadcast)            w_push = ~w_src;
         else if ({1'b0, w_dst} >= NDEV)    w_drop = 1'b1;
         else if (w_dst != r_gnt)           w_push = ONE << w_dst;
         else begin
`ifdef BUS_RR_LOOPBACK_EN
            w_push = w_src;
`else
            w_drop = 1'b1;
`endif
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_gnt      <= '0;
         r_rr_ptr   <= 8'(drvrs-1);
         r_data     <= '0;
         r_drop_cnt <= '0;
      end else begin
         if (r_state == S_IDLE && |pndng) r_gnt <= w_winner;
         if (r_state == S_POP) begin
            r_data   <= w_slice;
            r_rr_ptr <= r_gnt;
         end
         if (w_drop && r_drop_cnt != 16'hFFFF) r_drop_cnt <= r_drop_cnt + 16'd1;
      end
   end

   assign pop      = w_pop;
   assign push     = w_push;
   assign D_push   = r_data;
   assign busy     = w_busy;
   assign gnt_id   = r_gnt;
   assign drop_cnt = r_drop_cnt;

endmodule

// File: tb/tb_bus_rr_scheduler.sv
// Bench for bus_rr_scheduler: directed scenarios plus randomized traffic against a
// transaction-level reference model (grant search, destination rules, drop counting).
module tb_bus_rr_scheduler;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  pndng;
   logic [63:0] D_pop;
   logic [3:0]  pop;
   logic [3:0]  push;
   logic [15:0] D_push;
   logic        busy;
   logic [7:0]  gnt_id;
   logic [15:0] drop_cnt;

   int n_vec  = 0;
   int n_miss = 0;
   int m_rr;
   int m_drop;

   bus_rr_scheduler #(.drvrs(4), .pckg_sz(16), .broadcast(8'hFF)) dut (
      .clk(clk), .reset(reset), .pndng(pndng), .D_pop(D_pop), .pop(pop), .push(push),
      .D_push(D_push), .busy(busy), .gnt_id(gnt_id), .drop_cnt(drop_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_miss++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic int model_pick(input logic [3:0] pv);
      int w = -1;
      for (int k = 1; k <= 4; k++) begin
         if (w < 0 && ((pv >> ((m_rr + k) % 4)) & 4'd1) != 4'd0) w = (m_rr + k) % 4;
      end
      return w;
   endfunction

   function automatic logic [15:0] rand_pkt();
      logic [7:0] d;
      case ($urandom_range(0, 5))
         0: d = 8'd0;
         1: d = 8'd1;
         2: d = 8'd2;
         3: d = 8'd3;
         4: d = 8'hFF;
         default: d = 8'($urandom_range(4, 254));
      endcase
      return {d, 8'($urandom)};
   endfunction

   // One full grant/pop/route transaction starting from IDLE.
   task automatic xfer(input logic [3:0] pv, input logic [63:0] dp);
      int          w;
      logic [15:0] pkt;
      logic [7:0]  dst;
      logic [3:0]  exp_push;
      logic [3:0]  exp_pop;
      bit          drop;
      w = model_pick(pv);
      pkt = 16'(dp >> (w * 16));
      dst = pkt[15:8];
      exp_pop = 4'(1 << w);
      drop = 1'b0;
      if (dst == 8'hFF)               exp_push = 4'hF & ~exp_pop;
      else if (int'(dst) >= 4)        begin exp_push = 4'h0; drop = 1'b1; end
      else if (int'(dst) != w)        exp_push = 4'(1 << dst);
      else begin
`ifdef BUS_RR_LOOPBACK_EN
         exp_push = exp_pop;
`else
         exp_push = 4'h0;
         drop = 1'b1;
`endif
      end
      pndng = pv;
      D_pop = dp;
      @(posedge clk); #1;
      pndng = 4'($urandom);
      check("pop_grant", 32'(pop), 32'(exp_pop));
      check("gnt_id", 32'(gnt_id), 32'(w));
      check("busy_pop", 32'(busy), 32'd1);
      check("push_in_pop", 32'(push), 32'd0);
      @(posedge clk); #1;
      m_rr = w;
      check("pop_in_route", 32'(pop), 32'd0);
      check("push_route", 32'(push), 32'(exp_push));
      check("d_push_route", 32'(D_push), 32'(pkt));
      check("busy_route", 32'(busy), 32'd1);
      @(posedge clk); #1;
      if (drop && m_drop < 16'hFFFF) m_drop++;
      pndng = 4'h0;
      check("push_after", 32'(push), 32'd0);
      check("busy_after", 32'(busy), 32'd0);
      check("drop_cnt", 32'(drop_cnt), 32'(m_drop));
      check("d_push_hold", 32'(D_push), 32'(pkt));
   endtask

   task automatic do_reset();
      reset = 1'b1;
      pndng = 4'h0;
      @(posedge clk); #1;
      reset = 1'b0;
      m_rr = 3;
      m_drop = 0;
      check("rst_pop", 32'(pop), 32'd0);
      check("rst_push", 32'(push), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_gnt", 32'(gnt_id), 32'd0);
      check("rst_dpush", 32'(D_push), 32'd0);
      check("rst_drop", 32'(drop_cnt), 32'd0);
   endtask

   int order[6] = '{0, 1, 2, 3, 0, 1};

   initial begin
      reset = 1'b1;
      pndng = 4'h0;
      D_pop = '0;
      repeat (3) @(posedge clk);
      #1;
      do_reset();

      // Single unicast from device 1 to device 2
      xfer(4'b0010, {16'h0000, 16'h0000, 16'h02AB, 16'h0000});

      // Round-robin fairness with all devices pending
      do_reset();
      for (int k = 0; k < 6; k++) begin
         xfer(4'b1111, {16'h0033, 16'h0122, 16'h0311, 16'h0200});
         check("rr_order", 32'(gnt_id), 32'(order[k]));
      end

      // Broadcast from device 2
      xfer(4'b0100, {16'h0000, 16'hFF55, 16'h0000, 16'h0000});

      // Invalid destination, then self-destination
      do_reset();
      xfer(4'b0001, {16'h0000, 16'h0000, 16'h0000, 16'h0711});
      xfer(4'b0001, {16'h0000, 16'h0000, 16'h0000, 16'h0011});

      // Idle with nothing pending
      repeat (2) @(posedge clk);
      #1;
      check("idle_pop", 32'(pop), 32'd0);
      check("idle_busy", 32'(busy), 32'd0);

      // Reset while in POP
      xfer(4'b0100, {16'h0000, 16'h0100, 16'h0000, 16'h0000});
      pndng = 4'b1100;
      D_pop = {16'h0100, 16'h0000, 16'h0000, 16'h0000};
      @(posedge clk); #1;
      check("midrst_pop", 32'(pop), 32'h8);
      do_reset();
      xfer(4'b0110, {16'h0000, 16'h0300, 16'h0200, 16'h0000});
      check("post_rst_grant", 32'(gnt_id), 32'd1);

      // Drop counter saturation
      force dut.r_drop_cnt = 16'hFFFE;
      #1;
      release dut.r_drop_cnt;
      m_drop = 16'hFFFE;
      check("sat_preload", 32'(drop_cnt), 32'hFFFE);
      xfer(4'b0010, {16'h0000, 16'h0000, 16'h0944, 16'h0000});
      xfer(4'b0010, {16'h0000, 16'h0000, 16'h0A44, 16'h0000});
      xfer(4'b0010, {16'h0000, 16'h0000, 16'h0B44, 16'h0000});
      check("sat_hold", 32'(drop_cnt), 32'hFFFF);

      // Randomized traffic
      do_reset();
      for (int k = 0; k < 60; k++) begin
         xfer(4'($urandom_range(1, 15)), {rand_pkt(), rand_pkt(), rand_pkt(), rand_pkt()});
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/bus_rr_scheduler.md
# bus_rr_scheduler

Round-robin scheduler and router for the shared packet bus that connects `drvrs` device FIFOs.
- Each cycle it watches every device's `pndng` flag and grants exactly one device.
- It pops that device's head packet and decodes the destination ID in the packet header.
- It pushes the packet to the destination device, or to all other devices on a broadcast.
- It sits between the per-device FIFO interfaces (`pndng`/`pop`/`D_pop`, `push`/`D_push`) and replaces ad-hoc fixed-priority bus control.

## Interface
Parameters:
- `drvrs`, 4 — number of devices on the bus; valid range 2..255.
- `pckg_sz`, 16 — packet width in bits; minimum 9.
- `broadcast`, 8'hFF — destination ID meaning "all devices except the source".

Ports (one clock; reset is synchronous and active-high):
- `clk`, input, 1 — bus clock; all state changes on its rising edge.
- `reset`, input, 1 — synchronous, active-high; sampled on the rising edge of `clk`.
- `pndng`, input, `drvrs` — bit i high means device i's FIFO holds at least one packet.
- `D_pop`, input, `drvrs*pckg_sz` — head packet of each device; slice i is `[i*pckg_sz +: pckg_sz]`.
- `pop`, output, `drvrs` — one-hot pop strobe to the granted device.
- `push`, output, `drvrs` — push strobes to destination devices; one-hot, or multi-hot on broadcast.
- `D_push`, output, `pckg_sz` — shared bus data to all devices; valid while any `push` bit is high.
- `busy`, output, 1 — high in the POP and ROUTE states.
- `gnt_id`, output, 8 — index of the last granted device.
- `drop_cnt`, output, 16 — count of dropped packets; saturates at 16'hFFFF.

## Operation
Packet header:
- Destination ID = bits `[pckg_sz-1 : pckg_sz-8]`.
- The payload is forwarded unmodified, header included.

FSM states: IDLE, POP, ROUTE.
- **IDLE:**
  - If `pndng` is nonzero, choose the winner: the first set bit searching upward from `rr_ptr+1`, wrapping modulo `drvrs`.
  - Register the winner into `gnt_id` and go to POP.
  - Otherwise stay in IDLE.
- **POP:**
  - Assert `pop[gnt_id]` for exactly one cycle.
  - Capture slice `gnt_id` of `D_pop` into the data register on the same edge.
  - Set `rr_ptr <= gnt_id`, then go to ROUTE.
- **ROUTE:** decode the destination ID `dst` and drive `D_push` = captured packet for one cycle.
  - `dst == broadcast`: `push` = all ones except bit `gnt_id`.
  - `dst < drvrs` and `dst != gnt_id`: `push` = one-hot `dst`.
  - `dst >= drvrs` (and not `broadcast`): packet is dropped; `push` stays 0; `drop_cnt` increments.
  - `dst == gnt_id`: behaviour is set by `BUS_RR_LOOPBACK_EN` (see Configuration).
  - Next state is always IDLE.

Round-robin properties:
- `rr_ptr` resets to `drvrs-1`, so the first grant goes to the lowest-index pending device.
- Each pending device is served within `drvrs` grants.

`pndng` is sampled only in IDLE; changes during POP and ROUTE are ignored.

## Timing
- Latency: `pndng` seen high at edge N (in IDLE) → `pop` high in cycle N+1 → `push`/`D_push` valid in cycle N+2.
- Throughput: one packet per 3 cycles.
- `pop` and `push` are never asserted in the same cycle. `pop` is never asserted to more than one device at a time.
- `D_push` holds its last value outside ROUTE; consumers qualify it with `push`.
- Reset values: `pop` = 0, `push` = 0, `D_push` = 0, `busy` = 0, `gnt_id` = 0, `drop_cnt` = 0, state = IDLE, `rr_ptr` = `drvrs-1`.
- Reset asserted mid-transfer takes priority over all transitions.
  - Outputs return to their reset values on the next edge.
  - A packet already popped but not yet pushed is lost and not counted in `drop_cnt`.
- `drop_cnt` saturates: it holds at 16'hFFFF and never wraps.
- Wrap-around: when `rr_ptr == drvrs-1`, the search begins at index 0.

## Configuration
`BUS_RR_LOOPBACK_EN`:
- Defined: a packet with `dst == gnt_id` is pushed back to its source (`push` = one-hot `gnt_id`) and is not counted as a drop.
- Undefined: such a packet is dropped; `push` stays 0 and `drop_cnt` increments.
- Broadcast never includes the source in either build.

## Test plan
1. **Single unicast.** `drvrs`=4. Device 1 pending with 16'h02AB.
   - Required: `pop` = 4'b0010 in cycle N+1.
   - Required: `push` = 4'b0100 and `D_push` = 16'h02AB in cycle N+2.
   - Required: `drop_cnt` = 0.
2. **Round-robin fairness.** All four devices pending continuously.
   - Required: grant order 0, 1, 2, 3, 0, 1.
   - Required: `pop` one-hot throughout, one grant every 3 cycles.
3. **Broadcast.** Device 2 sends 16'hFF55.
   - Required: `push` = 4'b1011 and `D_push` = 16'hFF55 for exactly one cycle.
4. **Invalid destination.** Device 0 sends 16'h0711.
   - Required: no `push` asserted; `drop_cnt` goes 0 → 1.
   - Then device 0 sends 16'h0011.
   - Required with `BUS_RR_LOOPBACK_EN`: `push` = 4'b0001.
   - Required without it: no `push`; `drop_cnt` = 2.
5. **Reset mid-transfer.** Assert `reset` for one cycle while in POP.
   - Required: `pop`, `push`, `busy` = 0 on the next edge; `rr_ptr` restored.
   - Required: the next grant goes to the lowest-index pending device.
6. **Saturation.** Preload `drop_cnt` via 65 537 invalid packets, or force it in the bench.
   - Required: `drop_cnt` holds at 16'hFFFF.
